compute_dispatcher: RTL and testbench

Parametrised command dispatcher that sits between the host UART transceiver and a bank of compute units (adder, subtractor, multiplier link, echo, and similar). Each received command carries an opcode and two operands. The block latches the operands and starts exactly one selected unit with a single-cycle pulse. It then waits for that unit's done, returns its result with a one-cycle write strobe, and reports bad opcodes, busy collisions and (optionally) unit timeouts.

---
 rtl/compute_dispatcher.sv | 160 ++++++++++++++++
 tb/tb_compute_dispatcher.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/compute_dispatcher.sv
// Command dispatcher: latches operands, starts one compute unit, returns its result.
// Optional unit watchdog enabled by defining DISPATCH_TIMEOUT_EN.
module compute_dispatcher #(
    parameter int unsigned OPW            = 64,
    parameter int unsigned OPC_W          = 2,
    parameter int unsigned NUM_UNITS      = 4,
    parameter int unsigned RES_W          = 128,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [OPC_W+2*OPW-1:0]       rx_data,
    input  logic                         rx_irq,
    output logic [RES_W-1:0]             tx_data,
    output logic                         tx_wr,
    output logic [OPW-1:0]               unit_a,
    output logic [OPW-1:0]               unit_b,
    output logic [NUM_UNITS-1:0]         unit_start,
    input  logic [NUM_UNITS-1:0]         unit_done,
    input  logic [NUM_UNITS*RES_W-1:0]   unit_result,
    output logic                         busy,
    output logic                         err_opcode,
    output logic                         err_busy,
    output logic                         timeout
);

    localparam int unsigned CMD_W = OPC_W + 2 * OPW;

    // Elaboration-time guard against unusable configurations
    generate
        if (NUM_UNITS < 1 || NUM_UNITS > (1 << OPC_W) || TIMEOUT_CYCLES < 1) begin : g_param_check
            $error("compute_dispatcher: illegal NUM_UNITS or TIMEOUT_CYCLES");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        SEND  = 2'd3
    } state_t;

    state_t             state;
    logic [OPC_W-1:0]   sel;

    logic [OPC_W-1:0]   cmd_opc;
    logic [OPW-1:0]     cmd_a;
    logic [OPW-1:0]     cmd_b;
    logic               cmd_ok;
    logic [NUM_UNITS-1:0] cmd_onehot;
    logic               sel_done;
    logic [RES_W-1:0]   sel_result;

    // Command field decode
    always_comb begin
        cmd_opc    = rx_data[CMD_W-1 -: OPC_W];
        cmd_a      = rx_data[2*OPW-1 -: OPW];
        cmd_b      = rx_data[OPW-1:0];
        cmd_ok     = (32'(cmd_opc) < NUM_UNITS);
        cmd_onehot = NUM_UNITS'(1) << cmd_opc;
    end

    // Only the selected unit's done/result are visible to the FSM
    always_comb begin
        sel_done   = 1'b0;
        sel_result = '0;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            if (sel == OPC_W'(i)) begin
                sel_done   = unit_done[i];
                sel_result = unit_result[i*RES_W +: RES_W];
            end
        end
    end

`ifdef DISPATCH_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
`else
    assign timeout = 1'b0;
`endif

    // Dispatcher FSM with registered outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            sel        <= '0;
            tx_data    <= '0;
            tx_wr      <= 1'b0;
            unit_a     <= '0;
            unit_b     <= '0;
            unit_start <= '0;
            busy       <= 1'b0;
            err_opcode <= 1'b0;
            err_busy   <= 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
            timeout    <= 1'b0;
            wait_cnt   <= '0;
`endif
        end else begin
            unit_start <= '0;
            tx_wr      <= 1'b0;
            err_opcode <= 1'b0;
            err_busy   <= 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
            timeout    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (rx_irq) begin
                        sel    <= cmd_opc;
                        unit_a <= cmd_a;
                        unit_b <= cmd_b;
                        if (cmd_ok) begin
                            state      <= ISSUE;
                            busy       <= 1'b1;
                            unit_start <= cmd_onehot;
                        end else begin
                            err_opcode <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT;
`ifdef DISPATCH_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                WAIT: begin
                    if (sel_done) begin
                        tx_data <= sel_result;
                        tx_wr   <= 1'b1;
                        state   <= SEND;
`ifdef DISPATCH_TIMEOUT_EN
                    end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // Watchdog expired: return all ones with a timeout flag
                        tx_data <= '1;
                        tx_wr   <= 1'b1;
                        timeout <= 1'b1;
                        state   <= SEND;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
`endif
                    end
                end
                SEND: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
            if (rx_irq && state != IDLE) begin
                err_busy <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_compute_dispatcher.sv
// Randomized self-checking bench for compute_dispatcher; the bench plays the compute units.
// Define DISPATCH_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES=8).
module tb_compute_dispatcher;

    localparam int TMO = 8;

    logic         clock;
    logic         reset;
    logic [129:0] rx_data;
    logic         rx_irq;
    logic [3:0]   unit_done;
    logic [511:0] unit_result;

    logic [127:0] tx_data;
    logic         tx_wr;
    logic [63:0]  unit_a, unit_b;
    logic [3:0]   unit_start;
    logic         busy, err_opcode, err_busy, timeout;

    logic [127:0] tx_data3;
    logic         tx_wr3;
    logic [63:0]  unit_a3, unit_b3;
    logic [2:0]   unit_start3;
    logic         busy3, err_opcode3, err_busy3, timeout3;

    int checks = 0;
    int passes = 0;

    compute_dispatcher #(.OPW(64), .OPC_W(2), .NUM_UNITS(4), .RES_W(128), .TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset), .rx_data(rx_data), .rx_irq(rx_irq),
        .tx_data(tx_data), .tx_wr(tx_wr), .unit_a(unit_a), .unit_b(unit_b),
        .unit_start(unit_start), .unit_done(unit_done), .unit_result(unit_result),
        .busy(busy), .err_opcode(err_opcode), .err_busy(err_busy), .timeout(timeout)
    );

    compute_dispatcher #(.OPW(64), .OPC_W(2), .NUM_UNITS(3), .RES_W(128), .TIMEOUT_CYCLES(TMO)) dut3 (
        .clock(clock), .reset(reset), .rx_data(rx_data), .rx_irq(rx_irq),
        .tx_data(tx_data3), .tx_wr(tx_wr3), .unit_a(unit_a3), .unit_b(unit_b3),
        .unit_start(unit_start3), .unit_done(unit_done[2:0]), .unit_result(unit_result[383:0]),
        .busy(busy3), .err_opcode(err_opcode3), .err_busy(err_busy3), .timeout(timeout3)
    );

    always #5 clock = ~clock;

    // What each emulated unit computes
    function automatic logic [127:0] model(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            2'd0:    return 128'(a) + 128'(b);
            2'd1:    return 128'(a) - 128'(b);
            2'd2:    return 128'(a) * 128'(b);
            default: return {a, b};
        endcase
    endfunction

    // Issue one command, act as the addressed unit and record what the dispatcher did
    task automatic do_cmd(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                          input int lat, input int noise_c, input int coll_c, input bit stop_on_wr,
                          input int max_c,
                          output int starts, output logic [3:0] start_val, output int wrs,
                          output int wr_at, output logic [127:0] wr_data, output int ebusy,
                          output int ab_bad, output int busy_cnt, output int tos, output int to_at);
        int done_at;
        done_at = -1;
        starts = 0; start_val = '0; wrs = 0; wr_at = -1; wr_data = '0;
        ebusy = 0; ab_bad = 0; busy_cnt = 0; tos = 0; to_at = -1;
        @(negedge clock);
        rx_data = {op, a, b};
        rx_irq  = 1'b1;
        for (int c = 1; c <= max_c; c++) begin
            @(negedge clock);
            rx_irq    = 1'b0;
            unit_done = '0;
            if (unit_start != 4'd0) begin
                starts++;
                start_val = unit_start;
                if (done_at < 0) done_at = c + lat;
            end
            if (tx_wr) begin wrs++; wr_at = c; wr_data = tx_data; end
            if (timeout) begin tos++; to_at = c; end
            if (err_busy) ebusy++;
            if (busy) begin
                busy_cnt++;
                if (unit_a !== a || unit_b !== b) ab_bad++;
            end
            if (c == done_at) begin
                unit_done[op] = 1'b1;
                unit_result[int'(op)*128 +: 128] = model(op, a, b);
            end
            if (c == noise_c) begin
                unit_done[0] = 1'b1;
                unit_result[127:0] = 128'hDEAD;
            end
            if (c == coll_c) begin
                rx_data = {~op, ~a, ~b};
                rx_irq  = 1'b1;
            end
            if (stop_on_wr && tx_wr) break;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        checks++;
        if ({tx_data, tx_wr, unit_a, unit_b, unit_start, busy, err_opcode, err_busy, timeout} !== '0)
            $display("FAIL reset_outputs: got tx_data=%h a=%h b=%h start=%b wr=%b busy=%b, need all 0",
                     tx_data, unit_a, unit_b, unit_start, tx_wr, busy);
        else passes++;
        checks++;
        if ({tx_data3, tx_wr3, unit_a3, unit_b3, unit_start3, busy3, err_opcode3, err_busy3, timeout3} !== '0)
            $display("FAIL reset_outputs_n3: got nonzero outputs, need all 0");
        else passes++;
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_echo();
        int st, wrs, wat, eb, abb, bc, tos, tat;
        logic [3:0] sv;
        logic [127:0] wd;
        logic [63:0] a, b;
        a = 64'h0123_4567_89AB_CDEF;
        b = 64'h1;
        do_cmd(2'd3, a, b, 1, -1, -1, 1'b0, 10, st, sv, wrs, wat, wd, eb, abb, bc, tos, tat);
        checks++; if (st !== 1 || sv !== 4'b1000) $display("FAIL echo_start: got %0d pulses val=%b, need 1 pulse 1000", st, sv); else passes++;
        checks++; if (wrs !== 1 || wat !== 3) $display("FAIL echo_wr: got %0d strobes at cycle %0d, need 1 at 3", wrs, wat); else passes++;
        checks++; if (wd !== {a, b}) $display("FAIL echo_data: got %h, need %h", wd, {a, b}); else passes++;
        checks++; if (bc !== 3) $display("FAIL echo_busy: got %0d busy cycles, need 3", bc); else passes++;
    endtask

    task automatic test_random();
        int st, wrs, wat, eb, abb, bc, tos, tat, lat;
        logic [3:0] sv;
        logic [127:0] wd;
        logic [63:0] a, b;
        logic [1:0] op;
        for (int n = 0; n < 16; n++) begin
            op  = 2'($urandom_range(0, 3));
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            lat = $urandom_range(1, 6);
            do_cmd(op, a, b, lat, -1, -1, 1'b0, lat + 8, st, sv, wrs, wat, wd, eb, abb, bc, tos, tat);
            checks++; if (st !== 1 || sv !== (4'd1 << op)) $display("FAIL rand_start[%0d]: got %0d pulses val=%b op=%0d", n, st, sv, op); else passes++;
            checks++; if (wrs !== 1 || wat !== lat + 2) $display("FAIL rand_wr[%0d]: got %0d strobes at %0d, need 1 at %0d", n, wrs, wat, lat + 2); else passes++;
            checks++; if (wd !== model(op, a, b)) $display("FAIL rand_data[%0d]: got %h, need %h", n, wd, model(op, a, b)); else passes++;
            checks++; if (bc !== lat + 2 || abb !== 0) $display("FAIL rand_busy[%0d]: got busy=%0d ab_bad=%0d, need %0d and 0", n, bc, abb, lat + 2); else passes++;
            checks++; if (tos !== 0 || eb !== 0) $display("FAIL rand_flags[%0d]: got timeout=%0d err_busy=%0d, need 0", n, tos, eb); else passes++;
        end
    endtask

    task automatic test_wrong_unit();
        int st, wrs, wat, eb, abb, bc, tos, tat;
        logic [3:0] sv;
        logic [127:0] wd;
        do_cmd(2'd2, 64'h5, 64'h7, 6, 2, -1, 1'b0, 14, st, sv, wrs, wat, wd, eb, abb, bc, tos, tat);
        checks++; if (wrs !== 1 || wat !== 8) $display("FAIL wrong_unit_wr: got %0d strobes at %0d, need 1 at 8", wrs, wat); else passes++;
        checks++; if (wd !== 128'd35) $display("FAIL wrong_unit_data: got %h, need %h", wd, 128'd35); else passes++;
    endtask

    task automatic test_bad_opcode();
        int eo, st, wr, bz;
        logic [63:0] a, b;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        eo = 0; st = 0; wr = 0; bz = 0;
        @(negedge clock);
        rx_data = {2'd3, a, b};
        rx_irq  = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            rx_irq    = 1'b0;
            unit_done = '0;
            if (err_opcode3) eo++;
            if (unit_start3 != 3'd0) st++;
            if (tx_wr3) wr++;
            if (busy3) bz++;
            if (c == 2) begin unit_done[3] = 1'b1; unit_result[511:384] = model(2'd3, a, b); end
        end
        checks++; if (eo !== 1) $display("FAIL bad_opcode_err: got %0d pulses, need 1", eo); else passes++;
        checks++; if (st !== 0 || wr !== 0 || bz !== 0) $display("FAIL bad_opcode_quiet: got start=%0d wr=%0d busy=%0d, need 0", st, wr, bz); else passes++;
        checks++; if (unit_a3 !== a || unit_b3 !== b) $display("FAIL bad_opcode_latch: got a=%h b=%h, need a=%h b=%h", unit_a3, unit_b3, a, b); else passes++;
    endtask

    task automatic test_busy_collision();
        int st, wrs, wat, eb, abb, bc, tos, tat, cc;
        logic [3:0] sv;
        logic [127:0] wd;
        logic [63:0] a, b;
        logic [1:0] op;
        for (int k = 0; k < 3; k++) begin
            op = 2'($urandom_range(0, 3));
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            cc = (k == 0) ? 1 : (k == 1) ? 3 : 7;
            do_cmd(op, a, b, 5, -1, cc, 1'b0, 14, st, sv, wrs, wat, wd, eb, abb, bc, tos, tat);
            checks++; if (eb !== 1) $display("FAIL collision_err[%0d]: got %0d err_busy pulses, need 1", k, eb); else passes++;
            checks++; if (abb !== 0 || st !== 1) $display("FAIL collision_regs[%0d]: got ab_bad=%0d starts=%0d, need 0 and 1", k, abb, st); else passes++;
            checks++; if (wrs !== 1 || wd !== model(op, a, b)) $display("FAIL collision_data[%0d]: got %0d strobes data=%h, need 1 data=%h", k, wrs, wd, model(op, a, b)); else passes++;
        end
    endtask

    task automatic test_back_to_back();
        int st, wrs, wat, eb, abb, bc, tos, tat;
        logic [3:0] sv;
        logic [127:0] wd;
        logic [63:0] a, b;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        do_cmd(2'd0, a, b, 1, -1, -1, 1'b1, 10, st, sv, wrs, wat, wd, eb, abb, bc, tos, tat);
        checks++; if (wrs !== 1 || wat !== 3 || wd !== model(2'd0, a, b)) $display("FAIL b2b_first: got %0d strobes at %0d data=%h", wrs, wat, wd); else passes++;
        do_cmd(2'd1, b, a, 2, -1, -1, 1'b0, 10, st, sv, wrs, wat, wd, eb, abb, bc, tos, tat);
        checks++; if (st !== 1 || sv !== 4'b0010 || eb !== 0) $display("FAIL b2b_accept: got starts=%0d val=%b err_busy=%0d, need 1 0010 0", st, sv, eb); else passes++;
        checks++; if (wrs !== 1 || wat !== 4 || wd !== model(2'd1, b, a)) $display("FAIL b2b_second: got %0d strobes at %0d data=%h, need at 4 data=%h", wrs, wat, wd, model(2'd1, b, a)); else passes++;
    endtask

    task automatic test_reset_mid_wait();
        int wr, bz, st, wrs, wat, eb, abb, bc, tos, tat;
        logic [3:0] sv;
        logic [127:0] wd;
        wr = 0; bz = 0;
        @(negedge clock);
        rx_data = {2'd1, 64'h99, 64'h11};
        rx_irq  = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            rx_irq    = 1'b0;
            unit_done = '0;
            if (c == 4) reset = 1'b0;
            if (c == 5) begin
                reset = 1'b1;
                checks++;
                if ({tx_data, tx_wr, unit_a, unit_b, unit_start, busy, err_opcode, err_busy, timeout} !== '0)
                    $display("FAIL reset_mid_outputs: got tx_data=%h a=%h b=%h busy=%b, need all 0", tx_data, unit_a, unit_b, busy);
                else passes++;
            end
            if (c > 5) begin
                if (tx_wr) wr++;
                if (busy) bz++;
            end
            if (c == 6) begin unit_done[1] = 1'b1; unit_result[255:128] = 128'h77; end
        end
        checks++; if (wr !== 0 || bz !== 0) $display("FAIL reset_mid_late_done: got wr=%0d busy=%0d, need 0", wr, bz); else passes++;
        do_cmd(2'd1, 64'h99, 64'h11, 2, -1, -1, 1'b0, 10, st, sv, wrs, wat, wd, eb, abb, bc, tos, tat);
        checks++; if (wrs !== 1 || wat !== 4 || wd !== 128'h88) $display("FAIL reset_mid_recover: got %0d strobes at %0d data=%h, need 1 at 4 data=88", wrs, wat, wd); else passes++;
    endtask

`ifdef DISPATCH_TIMEOUT_EN
    task automatic test_timeout();
        int st, wrs, wat, eb, abb, bc, tos, tat;
        logic [3:0] sv;
        logic [127:0] wd;
        do_cmd(2'd1, 64'h3, 64'h4, 1000, -1, -1, 1'b0, 20, st, sv, wrs, wat, wd, eb, abb, bc, tos, tat);
        checks++; if (wrs !== 1 || wat !== TMO + 2 || wd !== '1) $display("FAIL timeout_wr: got %0d strobes at %0d data=%h, need 1 at %0d all ones", wrs, wat, wd, TMO + 2); else passes++;
        checks++; if (tos !== 1 || tat !== wat) $display("FAIL timeout_pulse: got %0d pulses at %0d, need 1 at %0d", tos, tat, wat); else passes++;
        checks++; if (bc !== TMO + 2) $display("FAIL timeout_idle: got %0d busy cycles, need %0d", bc, TMO + 2); else passes++;
        do_cmd(2'd2, 64'h6, 64'h9, TMO, -1, -1, 1'b0, 20, st, sv, wrs, wat, wd, eb, abb, bc, tos, tat);
        checks++; if (wrs !== 1 || wd !== 128'd54 || tos !== 0) $display("FAIL timeout_done_wins: got %0d strobes data=%h timeouts=%0d, need 1 data=36 0", wrs, wd, tos); else passes++;
    endtask
`endif

    initial begin
        clock       = 1'b0;
        reset       = 1'b0;
        rx_irq      = 1'b0;
        rx_data     = '0;
        unit_done   = '0;
        unit_result = '0;
        test_reset();
        test_echo();
        test_random();
        test_wrong_unit();
        test_bad_opcode();
        test_busy_collision();
        test_back_to_back();
        test_reset_mid_wait();
`ifdef DISPATCH_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
